// File: rtl/wb_buffer_pkg.sv
// Shared RISC-V register-file constants and helpers for the write-back buffer.
package wb_buffer_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    // x0 is hardwired to zero, so writes to it are never buffered or bypassed.
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_buffer_if.sv
// Pipeline, register-file and bypass signals of the write-back buffer.
interface wb_buffer_if
    import wb_buffer_pkg::cnt_width;
#(
    parameter int unsigned DATA_WIDTH = wb_buffer_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = wb_buffer_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_rd;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    logic                  rf_stall;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    logic [CNT_W-1:0]      count;

    modport master (
        output wr_valid, wr_rd, wr_data, rf_stall, rs1_addr, rs2_addr,
        input  wr_ready, rf_we, rf_waddr, rf_wdata, rs1_hit, rs2_hit, rs1_data, rs2_data, count
    );

    modport slave (
        input  wr_valid, wr_rd, wr_data, rf_stall, rs1_addr, rs2_addr,
        output wr_ready, rf_we, rf_waddr, rf_wdata, rs1_hit, rs2_hit, rs1_data, rs2_data, count
    );

endinterface

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the occupied write-back entries for one read port.
module wb_bypass_match
    import wb_buffer_pkg::ZERO_REG;
#(
    parameter int unsigned DATA_WIDTH = wb_buffer_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = wb_buffer_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0]  entry_rd,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  entry_data,
    input  logic [DEPTH-1:0]                  entry_valid,
    input  logic [PTR_W-1:0]                  rd_ptr,
    output logic                              hit,
    output logic [DATA_WIDTH-1:0]             data
);

    logic [PTR_W-1:0] slot;

    // Walk from oldest to youngest so the last match seen wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            slot = rd_ptr + PTR_W'(k);
            if (entry_valid[slot] && (entry_rd[slot] == addr) &&
                (addr != ADDR_WIDTH'(ZERO_REG))) begin
                hit  = 1'b1;
                data = entry_data[slot];
            end
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// Circular write-back buffer between the pipeline and the register-file write port,
// with combinational bypass of pending writes to two read ports.
module wb_buffer
    import wb_buffer_pkg::ZERO_REG;
#(
    parameter int unsigned DATA_WIDTH = wb_buffer_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = wb_buffer_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input logic        clk,
    input logic        rst,
    wb_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] rd_mem;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_mem;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ready;
    logic             not_empty;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0] age;

    always_comb begin
        not_empty = (count_q != '0);
        // Ready comes from the registered count only, so a dequeue from full
        // frees a slot for the following cycle, not this one.
        ready     = (count_q != FULL);
        deq       = not_empty && !bus.rf_stall;
        enq       = bus.wr_valid && ready && (bus.wr_rd != ADDR_WIDTH'(ZERO_REG));

        wr_ptr_d  = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_comb begin
        bus.wr_ready = ready;
        bus.rf_we    = deq;
        bus.count    = count_q;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (not_empty) begin
            bus.rf_waddr = rd_mem[rd_ptr_q];
            bus.rf_wdata = data_mem[rd_ptr_q];
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        slot_valid = '0;
        age        = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            age           = PTR_W'(i) - rd_ptr_q;
            slot_valid[i] = ({1'b0, age} < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uncleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wr_ptr_q]   <= bus.wr_rd;
            data_mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    wb_bypass_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_match_rs1 (
        .addr        (bus.rs1_addr),
        .entry_rd    (rd_mem),
        .entry_data  (data_mem),
        .entry_valid (slot_valid),
        .rd_ptr      (rd_ptr_q),
        .hit         (bus.rs1_hit),
        .data        (bus.rs1_data)
    );

    wb_bypass_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_match_rs2 (
        .addr        (bus.rs2_addr),
        .entry_rd    (rd_mem),
        .entry_data  (data_mem),
        .entry_valid (slot_valid),
        .rd_ptr      (rd_ptr_q),
        .hit         (bus.rs2_hit),
        .data        (bus.rs2_data)
    );

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: directed scenarios plus random traffic against a
// queue-based model of the pending writes.
module tb_wb_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t model_q[$];

    always #5 clk = ~clk;

    wb_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    wb_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest pending write to addr, or a miss for x0 and unmatched indices.
    task automatic lookup(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_q[i].rd == a) begin
                    hit = 1'b1;
                    d   = model_q[i].data;
                    break;
                end
            end
        end
    endtask

    // Drive one cycle after the falling edge, check outputs, then apply the rising edge.
    task automatic step(input logic r, input logic st, input logic v, input logic [AW-1:0] rd,
                        input logic [DW-1:0] d, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        logic          e_ready, e_we, h1, h2;
        logic [DW-1:0] d1, d2;
        rst          = r;
        bus.rf_stall = st;
        bus.wr_valid = v;
        bus.wr_rd    = rd;
        bus.wr_data  = d;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        #2;
        e_ready = (model_q.size() != DEPTH);
        e_we    = (model_q.size() != 0) && !st;
        lookup(a1, h1, d1);
        lookup(a2, h2, d2);
        chk("wr_ready", 64'(bus.wr_ready), 64'(e_ready));
        chk("count", 64'(bus.count), 64'(model_q.size()));
        chk("rf_we", 64'(bus.rf_we), 64'(e_we));
        chk("rf_waddr", 64'(bus.rf_waddr), (model_q.size() != 0) ? 64'(model_q[0].rd) : 64'd0);
        chk("rf_wdata", 64'(bus.rf_wdata), (model_q.size() != 0) ? 64'(model_q[0].data) : 64'd0);
        chk("rs1_hit", 64'(bus.rs1_hit), 64'(h1));
        chk("rs1_data", 64'(bus.rs1_data), 64'(d1));
        chk("rs2_hit", 64'(bus.rs2_hit), 64'(h2));
        chk("rs2_data", 64'(bus.rs2_data), 64'(d2));
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            if (e_we) void'(model_q.pop_front());
            if (v && e_ready && rd != 0) model_q.push_back('{rd: rd, data: d});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        step(1'b0, st, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_rd    = '0;
        bus.wr_data  = '0;
        bus.rf_stall = 1'b0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, checked with reset still held.
        step(1'b1, 1'b0, 1'b0, '0, '0, 5'd3, 5'd4);

        // Single write drains the cycle after it is accepted.
        step(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        chk("r038_we", 64'(bus.rf_we), 64'd1);
        chk("r038_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("r038_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        idle(1'b0);
        chk("r038_count", 64'(bus.count), 64'd0);

        // Fill under stall, reject a fifth, then drain in order.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, AW'(i), DW'(32'h100 + i), 5'd2, 5'd9);
        chk("r039_count", 64'(bus.count), 64'd4);
        chk("r039_ready", 64'(bus.wr_ready), 64'd0);
        step(1'b0, 1'b1, 1'b1, 5'd9, 32'h999, 5'd9, 5'd4);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0, 5'd3, 5'd4);
        end
        chk("r039_empty", 64'(bus.count), 64'd0);

        // Youngest match wins on a duplicated destination.
        step(1'b0, 1'b1, 1'b1, 5'd7, 32'h11, 5'd7, 5'd8);
        step(1'b0, 1'b1, 1'b1, 5'd7, 32'h22, 5'd7, 5'd8);
        step(1'b0, 1'b1, 1'b0, '0, '0, 5'd7, 5'd8);
        chk("r040_hit1", 64'(bus.rs1_hit), 64'd1);
        chk("r040_data1", 64'(bus.rs1_data), 64'h22);
        chk("r040_hit2", 64'(bus.rs2_hit), 64'd0);
        repeat (3) idle(1'b0);

        // x0 writes complete the handshake but leave nothing behind.
        step(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
        chk("r041_count", 64'(bus.count), 64'd0);
        chk("r041_we", 64'(bus.rf_we), 64'd0);
        idle(1'b0);

        // Full buffer: drain frees a slot only on the following cycle.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, AW'(i + 10), DW'(i), 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 5'd20, 32'hABCD, 5'd20, 5'd11);
        chk("r042_count3", 64'(bus.count), 64'd3);
        step(1'b0, 1'b0, 1'b1, 5'd20, 32'hABCD, 5'd20, 5'd12);
        chk("r042_still3", 64'(bus.count), 64'd3);
        repeat (4) idle(1'b0);

        // Reset dominates a pending queue and an incoming request.
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, AW'(i), DW'(i), 5'd0, 5'd0);
        step(1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 5'd1, 5'd6);
        chk("r043_count", 64'(bus.count), 64'd0);
        chk("r043_hit1", 64'(bus.rs1_hit), 64'd0);
        chk("r043_hit2", 64'(bus.rs2_hit), 64'd0);

        // Random traffic biased to a few registers so bypass matches are frequent.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), DW'($urandom),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of register data.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 Parameter DEPTH, default 4, number of pending-write entries; SHALL be a power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_valid  in  1  write-back request from the pipeline.
REQ-007 wr_rd  in  ADDR_WIDTH  destination register index.
REQ-008 wr_data  in  DATA_WIDTH  destination register value.
REQ-009 wr_ready  out  1  buffer accepts a request this cycle.
REQ-010 rf_stall  in  1  register-file write port busy this cycle.
REQ-011 rf_we  out  1  register write enable, drives the register en.
REQ-012 rf_waddr  out  ADDR_WIDTH  register selected for write.
REQ-013 rf_wdata  out  DATA_WIDTH  value driven to the register D.
REQ-014 rs1_addr, rs2_addr  in  ADDR_WIDTH each  read-port indices for bypass lookup.
REQ-015 rs1_hit, rs2_hit  out  1 each  matching pending write exists.
REQ-016 rs1_data, rs2_data  out  DATA_WIDTH each  value of youngest matching pending entry.
REQ-017 count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Buffer SHALL be a circular FIFO with write pointer, read pointer and occupancy counter.
REQ-019 Enqueue SHALL occur when wr_valid && wr_ready && wr_rd != 0.
REQ-020 Requests with wr_rd == 0 SHALL be accepted (handshake completes) and discarded; no entry, no count change.
REQ-021 wr_ready SHALL equal (count != DEPTH), independent of wr_valid and rf_stall.
REQ-022 rf_we SHALL equal (count != 0) && !rf_stall; rf_waddr/rf_wdata SHALL show the oldest entry whenever count != 0, and all-zero when empty.
REQ-023 Dequeue SHALL occur on every cycle rf_we is 1.
REQ-024 Latency: entry enqueued in cycle N SHALL be presented with rf_we no earlier than cycle N+1; no same-cycle pass-through.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged; both pointers advance.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 Full: no enqueue; a dequeue in the same cycle SHALL NOT raise wr_ready until the next cycle.
REQ-028 Empty with rf_stall: no action, rf_we 0.
REQ-029 Bypass SHALL be combinational over occupied entries only; the same-cycle incoming request SHALL NOT be visible.
REQ-030 With multiple matches, rsN_data SHALL come from the youngest entry (closest to write pointer).
REQ-031 rsN_addr == 0 SHALL give rsN_hit 0 and rsN_data 0.
REQ-032 No match: rsN_hit 0, rsN_data 0.
REQ-033 Entries SHALL drain strictly in order; the buffer SHALL NOT merge or reorder writes.

Reset
REQ-034 rst SHALL clear pointers and count, giving wr_ready 1, rf_we 0, rf_waddr 0, rf_wdata 0, all hits 0, from the first cycle after the reset edge.
REQ-035 rst SHALL dominate simultaneous wr_valid and drain; pending entries SHALL be discarded, and entry storage contents SHALL not need clearing.

Structure
REQ-036 DATA_WIDTH, ADDR_WIDTH and the zero-register index constant SHALL live in the shared RISC-V package; DEPTH remains local.
REQ-037 Youngest-match priority search SHALL be one sub-module, wb_bypass_match, instantiated once per read port.

Verification
REQ-038 Reset, then wr_valid with rd=5, data=0xDEADBEEF, rf_stall=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; count returns to 0.
REQ-039 rf_stall=1, enqueue rd=1..4 -> count=4, wr_ready=0; fifth request not accepted; release stall -> drains rd 1,2,3,4 on four consecutive cycles.
REQ-040 rf_stall=1, enqueue rd=7 data=0x11 then rd=7 data=0x22; rs1_addr=7 -> rs1_hit=1, rs1_data=0x22; rs2_addr=8 -> rs2_hit=0, rs2_data=0.
REQ-041 wr_valid with rd=0, data=0xFFFF -> wr_ready=1, count stays 0, rf_we never asserts.
REQ-042 Full with rf_stall=0 and wr_valid=1 -> one dequeue, no enqueue, count=3; next cycle wr_ready=1 and the request enqueues, count stays 3.
REQ-043 rst asserted with 3 pending entries and wr_valid=1 -> next cycle count=0, rf_we=0, rsN_hit=0.
